// File: rtl/outputconditioner_pkg.sv
// Shared types and defaults for the output conditioner.
package outputconditioner_pkg;

    localparam int unsigned DEF_COUNTERWIDTH = 10;
    localparam int unsigned DEF_HOLDTIME     = 10;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // A level request: valid marks presence, value is the requested pin level.
    typedef struct packed {
        logic valid;
        logic value;
    } slot_t;

    // Both strobes together cancel out; otherwise the rise strobe gives the level.
    function automatic slot_t decode_request(input logic rise, input logic fall);
        slot_t r;
        r.valid = rise ^ fall;
        r.value = rise;
        return r;
    endfunction

    // A fresh request takes priority over whatever sits in the pending slot.
    function automatic slot_t pick_candidate(input slot_t req, input slot_t pend);
        slot_t c;
        c = req.valid ? req : pend;
        return c;
    endfunction

endpackage

// File: rtl/outputconditioner_hold_timer.sv
// Load-to-zero hold counter; done is high while the count sits at holdtime-1.
module hold_timer #(
    parameter int unsigned counterwidth = 10,
    parameter int unsigned holdtime     = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam logic [counterwidth-1:0] LAST = counterwidth'(holdtime - 1);

    logic [counterwidth-1:0] count;
    logic [counterwidth-1:0] count_next;

    // Restart on start, otherwise count up and park at the last value.
    always_comb begin
        count_next = count;
        if (start) begin
            count_next = '0;
        end else if (count != LAST) begin
            count_next = count + counterwidth'(1);
        end
    end

    // Count register with done registered from the upcoming count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_next;
            done  <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/outputconditioner.sv
// Turns rise/fall strobes into a pin level that holds each value for holdtime cycles.
module outputconditioner
    import outputconditioner_pkg::*;
#(
    parameter int unsigned counterwidth = DEF_COUNTERWIDTH,
    parameter int unsigned holdtime     = DEF_HOLDTIME
) (
    input  logic clk,
    input  logic reset,
    input  logic riserequest,
    input  logic fallrequest,
    input  logic clearoverrun,
    output logic pinout,
    output logic positiveedge,
    output logic negativeedge,
    output logic busy,
    output logic overrun
);

    state_t state;
    slot_t  pending;
    slot_t  req;
    slot_t  cand;
    logic   done;
    logic   final_edge;
    logic   apply;
    logic   store;
    logic   collide;

    // Decide whether this edge changes the pin, queues a request or flags an overrun.
    always_comb begin
        req        = decode_request(riserequest, fallrequest);
        cand       = pick_candidate(req, pending);
        final_edge = (state == HOLD) && done;
        apply      = 1'b0;
        store      = 1'b0;
        collide    = 1'b0;
        case (state)
            IDLE: begin
                apply = req.valid && (req.value != pinout);
            end
            HOLD: begin
                if (done) begin
                    apply = cand.valid && (cand.value != pinout);
                end else begin
                    store   = req.valid;
                    collide = req.valid && pending.valid && (pending.value != req.value);
                end
            end
            default: begin
                apply = 1'b0;
            end
        endcase
    end

    hold_timer #(
        .counterwidth(counterwidth),
        .holdtime    (holdtime)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .start(apply),
        .done (done)
    );

    // FSM, pin level, edge strobes, pending slot and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pinout       <= 1'b0;
            positiveedge <= 1'b0;
            negativeedge <= 1'b0;
            pending      <= '0;
            overrun      <= 1'b0;
        end else begin
            positiveedge <= apply && cand.value;
            negativeedge <= apply && !cand.value;
            if (apply) begin
                pinout <= cand.value;
            end

            if (apply) begin
                state <= HOLD;
            end else if (final_edge) begin
                state <= IDLE;
            end

            if (final_edge) begin
                pending <= '0;
            end else if (store) begin
                pending <= req;
            end

            if (collide) begin
                overrun <= 1'b1;
            end else if (clearoverrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // HOLD is the only busy state.
    assign busy = (state == HOLD);

endmodule

// File: tb/tb_outputconditioner.sv
// Randomized and directed check of outputconditioner against a timestamp-based model.
module tb_outputconditioner;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic reset;
    logic rise;
    logic fall;
    logic clr;
    logic [NDUT-1:0] pin;
    logic [NDUT-1:0] pe;
    logic [NDUT-1:0] ne;
    logic [NDUT-1:0] bsy;
    logic [NDUT-1:0] ovr;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: level, strobes, whether a hold is running, edge index of the
    // last pin change, pending request (-1 = none) and sticky overrun.
    int ht     [NDUT] = '{10, 1};
    int m_pin  [NDUT];
    int m_pe   [NDUT];
    int m_ne   [NDUT];
    int m_hold [NDUT];
    int m_lc   [NDUT];
    int m_pend [NDUT];
    int m_ovr  [NDUT];
    int ecount = 0;

    always #10 clk = ~clk;

    outputconditioner #(.counterwidth(10), .holdtime(10)) dut0 (
        .clk(clk), .reset(reset), .riserequest(rise), .fallrequest(fall),
        .clearoverrun(clr), .pinout(pin[0]), .positiveedge(pe[0]),
        .negativeedge(ne[0]), .busy(bsy[0]), .overrun(ovr[0])
    );

    outputconditioner #(.counterwidth(4), .holdtime(1)) dut1 (
        .clk(clk), .reset(reset), .riserequest(rise), .fallrequest(fall),
        .clearoverrun(clr), .pinout(pin[1]), .positiveedge(pe[1]),
        .negativeedge(ne[1]), .busy(bsy[1]), .overrun(ovr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_pin[i]  = 0;
            m_pe[i]   = 0;
            m_ne[i]   = 0;
            m_hold[i] = 0;
            m_lc[i]   = 0;
            m_pend[i] = -1;
            m_ovr[i]  = 0;
        end
    endtask

    task automatic model_change(input int i, input int v);
        m_pe[i]   = (v == 1) ? 1 : 0;
        m_ne[i]   = (v == 0) ? 1 : 0;
        m_pin[i]  = v;
        m_hold[i] = 1;
        m_lc[i]   = ecount;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input int r, input int f, input int c);
        int req;
        int val;
        int cand;
        int setov;
        ecount++;
        req = r ^ f;
        val = r;
        for (int i = 0; i < NDUT; i++) begin
            setov   = 0;
            m_pe[i] = 0;
            m_ne[i] = 0;
            if (m_hold[i] == 1 && ecount == m_lc[i] + ht[i]) begin
                cand = (req == 1) ? val : m_pend[i];
                m_pend[i] = -1;
                if (cand >= 0 && cand != m_pin[i]) model_change(i, cand);
                else m_hold[i] = 0;
            end else if (m_hold[i] == 1) begin
                if (req == 1) begin
                    if (m_pend[i] >= 0 && m_pend[i] != val) setov = 1;
                    m_pend[i] = val;
                end
            end else begin
                if (req == 1 && val != m_pin[i]) model_change(i, val);
            end
            if (setov == 1) m_ovr[i] = 1;
            else if (c == 1) m_ovr[i] = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s[%0d].pinout", tag, i), 32'(pin[i]), 32'(m_pin[i]));
            check($sformatf("%s[%0d].posedge", tag, i), 32'(pe[i]), 32'(m_pe[i]));
            check($sformatf("%s[%0d].negedge", tag, i), 32'(ne[i]), 32'(m_ne[i]));
            check($sformatf("%s[%0d].busy", tag, i), 32'(bsy[i]), 32'(m_hold[i]));
            check($sformatf("%s[%0d].overrun", tag, i), 32'(ovr[i]), 32'(m_ovr[i]));
            check($sformatf("%s[%0d].onestrobe", tag, i), 32'(pe[i] & ne[i]), 32'(0));
        end
    endtask

    task automatic step(input int r, input int f, input int c, input string tag);
        @(negedge clk);
        rise = 1'(r);
        fall = 1'(f);
        clr  = 1'(c);
        @(posedge clk);
        model_edge(r, f, c);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 0, 0, tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next clock.
    task automatic async_reset(input string tag);
        #4;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".pin_now"}, 32'(pin[0]), 32'(0));
        check({tag, ".busy_now"}, 32'(bsy[0]), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        rise  = 1'b0;
        fall  = 1'b0;
        clr   = 1'b0;
        @(posedge clk);
        model_edge(0, 0, 0);
        #1;
        compare_all({tag, ".post"});
    endtask

    initial begin
        reset = 1'b1;
        rise  = 1'b0;
        fall  = 1'b0;
        clr   = 1'b0;
        model_reset();
        #5;
        compare_all("init");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        model_edge(0, 0, 0);
        #1;
        compare_all("init.post");

        // Single rise from idle.
        step(1, 0, 0, "t2.rise");
        check("t2.pin", 32'(pin[0]), 32'(1));
        check("t2.pe", 32'(pe[0]), 32'(1));
        idle(11, "t2.hold");

        // Fall queued three cycles into a hold.
        step(0, 1, 0, "t3.pre");
        idle(10, "t3.pre");
        step(1, 0, 0, "t3.rise");
        idle(2, "t3.wait");
        step(0, 1, 0, "t3.fall");
        idle(20, "t3.hold");

        // Conflicting requests inside a hold set overrun, net level unchanged.
        step(1, 0, 0, "t4.rise");
        step(0, 0, 0, "t4.c1");
        step(0, 1, 0, "t4.fall");
        step(0, 0, 0, "t4.c3");
        step(1, 0, 0, "t4.rise2");
        idle(8, "t4.hold");
        check("t4.ovr", 32'(ovr[0]), 32'(1));
        check("t4.pin", 32'(pin[0]), 32'(1));
        check("t4.busy", 32'(bsy[0]), 32'(0));
        step(0, 0, 1, "t4.clr");
        check("t4.ovrclr", 32'(ovr[0]), 32'(0));

        // Simultaneous strobes are a no-op.
        step(1, 1, 0, "t5.both");
        step(1, 1, 0, "t5.both");
        idle(2, "t5.idle");

        // Request landing exactly on the final hold edge is applied there.
        step(0, 1, 0, "t6.fall");
        idle(9, "t6.hold");
        step(1, 0, 0, "t6.final");
        check("t6.pin", 32'(pin[0]), 32'(1));
        check("t6.pe", 32'(pe[0]), 32'(1));
        idle(12, "t6.after");

        // Reset in the middle of a hold.
        step(0, 1, 0, "t1.fall");
        idle(10, "t1.idle");
        step(1, 0, 0, "t1.rise");
        idle(5, "t1.mid");
        async_reset("t1.rst");

        // Overrun set beats a coincident clear.
        step(1, 0, 0, "ov.rise");
        step(0, 1, 1, "ov.store");
        step(1, 0, 1, "ov.collide");
        check("ov.setwins", 32'(ovr[0]), 32'(1));
        idle(10, "ov.idle");

        // Random traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd.rst");
            end else begin
                step(($urandom_range(0, 4) == 0) ? 1 : 0,
                     ($urandom_range(0, 4) == 0) ? 1 : 0,
                     ($urandom_range(0, 15) == 0) ? 1 : 0, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
